// File: rtl/mdu_if.sv
// Handshake/result bundle between the E stage and the multiply/divide unit.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, output B, output MDUOp, output start,
                  input busy, input HI, input LO);
  modport slave  (input A, input B, input MDUOp, input start,
                  output busy, output HI, output LO);
endinterface

// File: rtl/mdu.sv
// Iterative-latency multiply/divide unit with private HI/LO registers.
// Define MDU_MADD_EN to enable madd/maddu (MDUOp 7/8); otherwise they act as no-ops.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_n_q, lo_n_q;

  logic        is_mul, is_sgn, is_div, is_acc, is_mthi, is_mtlo;
  logic        accept;
  logic [63:0] mul_a, mul_b, prod, base, res;
  logic        a_neg, b_neg;
  logic [31:0] dvd, dvs, dvs_safe, quo, rem, div_hi, div_lo;
  logic [3:0]  lat;

  always_comb begin
    is_mul  = 1'b0;
    is_sgn  = 1'b0;
    is_div  = 1'b0;
    is_acc  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    case (bus.MDUOp)
      4'd1: begin is_mul = 1'b1; is_sgn = 1'b1; end
      4'd2: is_mul = 1'b1;
      4'd3: begin is_div = 1'b1; is_sgn = 1'b1; end
      4'd4: is_div = 1'b1;
      4'd5: is_mthi = 1'b1;
      4'd6: is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      4'd7: begin is_mul = 1'b1; is_sgn = 1'b1; is_acc = 1'b1; end
      4'd8: begin is_mul = 1'b1; is_acc = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Low 64 bits of a 64x64 product are correct for both signednesses.
  assign mul_a = {{32{is_sgn & bus.A[31]}}, bus.A};
  assign mul_b = {{32{is_sgn & bus.B[31]}}, bus.B};
  assign prod  = mul_a * mul_b;

  // Divide on magnitudes, then restore signs (quotient toward zero, remainder follows dividend).
  assign a_neg    = is_sgn & bus.A[31];
  assign b_neg    = is_sgn & bus.B[31];
  assign dvd      = a_neg ? -bus.A : bus.A;
  assign dvs      = b_neg ? -bus.B : bus.B;
  assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
  assign quo      = dvd / dvs_safe;
  assign rem      = dvd % dvs_safe;
  assign div_lo   = (a_neg ^ b_neg) ? -quo : quo;
  assign div_hi   = a_neg ? -rem : rem;

  // A start landing on the commit edge builds on the value being committed.
  assign base = (state_q == StBusy) ? {hi_n_q, lo_n_q} : {hi_q, lo_q};

  always_comb begin
    if (is_div) begin
      res = (bus.B == 32'd0) ? base : {div_hi, div_lo};
    end else begin
`ifdef MDU_MADD_EN
      res = is_acc ? (base + prod) : prod;
`else
      res = prod;
`endif
    end
  end

  assign lat    = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
  assign accept = bus.start & ((state_q == StIdle) | (cnt_q == 4'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_n_q  <= 32'd0;
      lo_n_q  <= 32'd0;
    end else begin
      if (state_q == StBusy) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_q    <= hi_n_q;
          lo_q    <= lo_n_q;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      end
      if (accept) begin
        if (is_mul | is_div) begin
          {hi_n_q, lo_n_q} <= res;
          cnt_q   <= lat;
          busy_q  <= 1'b1;
          state_q <= StBusy;
        end else if (is_mthi) begin
          hi_q <= bus.A;
        end else if (is_mtlo) begin
          lo_q <= bus.A;
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases then randomized ops vs. an arithmetic model.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: new HI/LO and busy length from the architectural rules.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n, output logic [31:0] nh, output logic [31:0] nl);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = a;
    sb = b;
    nh = exp_hi;
    nl = exp_lo;
    n  = 0;
    case (op)
      4'd1: begin sp = longint'(sa) * longint'(sb); {nh, nl} = sp; n = MC; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; {nh, nl} = up; n = MC; end
      4'd3: begin
        n = DC;
        if (b != 32'd0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            nl = a; nh = 32'd0;
          end else begin
            nl = sa / sb; nh = sa % sb;
          end
        end
      end
      4'd4: begin n = DC; if (b != 32'd0) begin nl = a / b; nh = a % b; end end
      4'd5: nh = a;
      4'd6: nl = a;
`ifdef MDU_MADD_EN
      4'd7: begin sp = longint'(sa) * longint'(sb); {nh, nl} = {exp_hi, exp_lo} + sp; n = MC; end
      4'd8: begin up = {32'd0, a} * {32'd0, b}; {nh, nl} = {exp_hi, exp_lo} + up; n = MC; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op; optionally poke an ignored mult start mid-busy.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    int n;
    logic [31:0] nh, nl;
    model(op, a, b, n, nh, nl);
    bus.MDUOp = op; bus.A = a; bus.B = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.MDUOp = 4'd0;
    if (n == 0) begin
      exp_hi = nh; exp_lo = nl;
      chk("busy_imm", {31'd0, bus.busy}, 32'd0);
    end else begin
      chk("busy_start", {31'd0, bus.busy}, 32'd1);
      chk("hi_hold", bus.HI, exp_hi);
      for (int i = 1; i < n; i++) begin
        if (poke && i == 2) begin
          bus.MDUOp = 4'd1; bus.A = $urandom; bus.B = $urandom; bus.start = 1'b1;
        end
        tick();
        bus.start = 1'b0; bus.MDUOp = 4'd0;
        chk("busy_run", {31'd0, bus.busy}, 32'd1);
      end
      tick();
      exp_hi = nh; exp_lo = nl;
      chk("busy_done", {31'd0, bus.busy}, 32'd0);
    end
    chk("hi", bus.HI, exp_hi);
    chk("lo", bus.LO, exp_lo);
  endtask

  initial begin
    int n;
    logic [31:0] nh, nl, a, b;
    logic [3:0] op;
    reset = 1'b1;
    bus.A = 32'd0; bus.B = 32'd0; bus.MDUOp = 4'd0; bus.start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);

    // Reset mid-divide discards the in-flight result.
    run_op(4'd5, 32'h0000_AAAA, 32'd0, 1'b0);
    bus.MDUOp = 4'd3; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.MDUOp = 4'd0;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstmid_hi", bus.HI, 32'd0);
    chk("rstmid_lo", bus.LO, 32'd0);
    tick();
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    for (int i = 0; i < DC; i++) tick();
    chk("rstmid_nocommit_hi", bus.HI, 32'd0);
    chk("rstmid_nocommit_lo", bus.LO, 32'd0);
    chk("rstmid_nobusy", {31'd0, bus.busy}, 32'd0);

    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(4'd4, 32'd7, 32'd2, 1'b0);
    run_op(4'd5, 32'h0000_1234, 32'd0, 1'b0);
    run_op(4'd3, 32'd55, 32'd0, 1'b1);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // mtlo presented on the commit edge of a divide.
    model(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n, nh, nl);
    bus.MDUOp = 4'd3; bus.A = 32'h8000_0000; bus.B = 32'hFFFF_FFFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.MDUOp = 4'd0;
    for (int i = 1; i < n; i++) tick();
    chk("b2b_busy_last", {31'd0, bus.busy}, 32'd1);
    bus.MDUOp = 4'd6; bus.A = 32'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.MDUOp = 4'd0;
    exp_hi = nh; exp_lo = 32'd5;
    chk("b2b_busy", {31'd0, bus.busy}, 32'd0);
    chk("b2b_hi", bus.HI, exp_hi);
    chk("b2b_lo", bus.LO, exp_lo);

    run_op(4'd5, 32'd0, 32'd0, 1'b0);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(4'd7, 32'd1, 32'd1, 1'b0);
    run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(4'd9, 32'd3, 32'd4, 1'b0);

    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 9));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      run_op(op, a, b, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the E stage of the 5-stage MIPS pipeline. Sits beside the combinational ALU and executes mult/multu/div/divu/mthi/mtlo into private HI/LO registers. Multi-cycle operations report `busy` so the hazard unit can stall any later MDU instruction; HI/LO feed the E-stage result mux for mfhi/mflo.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal 1..15
- `DIV_CYCLES`, 10, busy cycles for div/divu; legal 1..15

- `clk` input 1 — rising-edge clock
- `reset` input 1 — asynchronous, active-high; clears all state
- `A` input 32 — rs operand
- `B` input 32 — rt operand
- `MDUOp` input 4 — 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; others = none
- `start` input 1 — qualifies `MDUOp`; sampled on rising edge
- `busy` output 1 — high while a multi-cycle op runs
- `HI` output 32 — HI register
- `LO` output 32 — LO register

One clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, BUSY. 4-bit down-counter `cnt`; latched op kind, pending 32-bit `hi_n`/`lo_n`.
- IDLE, `start`=1, op ∈ {mult, multu, div, divu, madd, maddu}: compute and latch result into `hi_n`/`lo_n`; load `cnt` with `MULT_CYCLES`/`DIV_CYCLES`; go BUSY. HI/LO unchanged.
- IDLE, `start`=1, mthi: HI←A at that edge. mtlo: LO←A. No BUSY.
- IDLE, `start`=0 or op none/illegal: no change.
- BUSY: decrement `cnt`; on the edge where `cnt`=1, commit HI←`hi_n`, LO←`lo_n`, go IDLE.
- `start` while BUSY: ignored entirely (hazard unit guarantees it is stalled; no queueing).
- mult: signed 32×32→64, {HI,LO}. multu: unsigned.
- div: LO = quotient truncated toward zero, HI = remainder, sign of dividend. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. divu: unsigned.
- Divide by zero (B=0): full `DIV_CYCLES` busy, HI/LO left unchanged at commit.
- madd/maddu: {HI,LO} ← {HI,LO} + product (signed/unsigned product), 64-bit wrap; HI/LO used are the values at the start edge.

## Timing
- Reset: state IDLE, `cnt`=0, `busy`=0, HI=0, LO=0, pending registers 0; asynchronous, takes effect mid-op and discards the in-flight result.
- `busy` is registered: low in the start cycle, high for exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES), low again in the cycle new HI/LO are visible.
- Start at edge t → HI/LO new at edge t+N; `busy`=1 between edges t and t+N.
- mthi/mtlo: 1-cycle, visible after the start edge; `busy` stays 0.
- A new start is accepted at the same edge that commits (busy already low that cycle is not the case—`busy`=1 until commit edge), i.e. earliest next start is edge t+N, back-to-back with no bubble beyond the stall.
- HI/LO outputs are register outputs, no combinational path from A/B/MDUOp/start.

## Configuration
- `MDU_MADD_EN`: defined → MDUOp 7/8 execute madd/maddu as above. Undefined → 7/8 treated as none (no state change, `busy` stays 0); accumulate adder omitted.

## Test plan
- Reset mid-div: start div A=100,B=7, assert `reset` 3 cycles later → `busy`=0, HI=0, LO=0 immediately; no commit afterwards.
- mult A=0xFFFFFFFF, B=2 → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7,B=2 → LO=3, HI=1.
- mthi A=0x1234 then div by B=0 → busy 10 cycles, HI stays 0x1234, LO stays prior value; start of mult while busy ignored (HI/LO unaffected by it).
- div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0; back-to-back mtlo A=5 at commit edge+0 → LO=5 one cycle after.
- `MDU_MADD_EN` defined: HI=0, LO=0xFFFFFFFF, madd A=1,B=1 → HI=1, LO=0 after 5 cycles; undefined → HI/LO unchanged, `busy` never rises.
